// File: rtl/disp_page_sched.sv
// Page scheduler for the 4-digit hex display driver.
// Rotates through up to four loaded result pages, with a blank gap between pages.
module disp_page_sched #(
    parameter int unsigned DWELL     = 200_000_000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic [3:0]   wr_en,
    input  logic [127:0] wr_data,
    input  logic         clr,
    input  logic         step,
    input  logic         hold,
    output logic [31:0]  x,
    output logic         e,
    output logic [1:0]   page,
    output logic [3:0]   vld,
    output logic         swap
);

    localparam int unsigned MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW = $clog2(MAXC);
    localparam logic [CW-1:0] DW_END = CW'(DWELL - 1);
    localparam logic [CW-1:0] BL_END = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   preg [4];
    logic [1:0]    low;
    logic [1:0]    nxt;
    logic          any;
    logic          adv;

    // Offset 4 wraps to the current page, so a lone page selects itself.
    always_comb begin
        any = |vld;
        low = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (vld[k]) low = 2'(k);
        end
        nxt = page;
        for (int k = 4; k >= 1; k--) begin
            if (vld[page + 2'(k)]) nxt = page + 2'(k);
        end
        adv = ((cnt == DW_END) && !hold) || step;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vld <= '0;
            for (int i = 0; i < 4; i++) preg[i] <= '0;
        end else begin
            if (clr) vld <= '0;
            for (int i = 0; i < 4; i++) begin
                if (wr_en[i]) begin
                    preg[i] <= wr_data[32*i +: 32];
                    vld[i]  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            page  <= 2'd0;
            x     <= '0;
            e     <= 1'b0;
            swap  <= 1'b0;
            cnt   <= '0;
        end else begin
            swap <= 1'b0;
            case (state)
                IDLE: begin
                    e   <= 1'b0;
                    x   <= '0;
                    cnt <= '0;
                    if (any) begin
                        page  <= low;
                        x     <= preg[low];
                        e     <= 1'b1;
                        swap  <= 1'b1;
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (!vld[page]) begin
                        state <= IDLE;
                        e     <= 1'b0;
                        x     <= '0;
                        cnt   <= '0;
                    end else begin
                        e <= 1'b1;
                        x <= preg[page];
                        if (adv) begin
                            cnt <= '0;
                            if (nxt != page) begin
                                e     <= 1'b0;
                                state <= BLANK;
                            end
                        end else if (cnt != DW_END) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                BLANK: begin
                    e <= 1'b0;
                    if (!any) begin
                        state <= IDLE;
                        x     <= '0;
                        cnt   <= '0;
                    end else if (cnt == BL_END) begin
                        page  <= nxt;
                        x     <= preg[nxt];
                        e     <= 1'b1;
                        swap  <= 1'b1;
                        cnt   <= '0;
                        state <= SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed bench for disp_page_sched.
// Uses a short dwell and blank so that full rotations fit in a few hundred cycles.
module tb_disp_page_sched;

    logic         CLK = 1'b0;
    logic         RSTn;
    logic [3:0]   wr_en;
    logic [127:0] wr_data;
    logic         clr;
    logic         step;
    logic         hold;
    logic [31:0]  x;
    logic         e;
    logic [1:0]   page;
    logic [3:0]   vld;
    logic         swap;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_1111;
    localparam logic [31:0] D3 = 32'h4444_3333;

    disp_page_sched #(.DWELL(10), .BLANK_CYC(3)) dut (
        .CLK(CLK), .RSTn(RSTn), .wr_en(wr_en), .wr_data(wr_data),
        .clr(clr), .step(step), .hold(hold), .x(x), .e(e),
        .page(page), .vld(vld), .swap(swap)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic ee, input logic sw,
                       input logic [1:0] pg, input logic [31:0] xd);
        chk(tag, {28'd0, e, swap, page, x}, {28'd0, ee, sw, pg, xd});
    endtask

    // One full dwell plus gap; ends on the entry cycle of the next page.
    task automatic run_page(input logic [1:0] pg, input logic [31:0] xd);
        for (int i = 0; i < 10; i++) begin
            cyc("rot_show", 1'b1, i == 0, pg, xd);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            cyc("rot_blank", 1'b0, 1'b0, pg, xd);
            tick();
        end
    endtask

    initial begin
        RSTn = 1'b0;
        wr_en = '0;
        wr_data = '0;
        clr = 1'b0;
        step = 1'b0;
        hold = 1'b0;
        tick();
        tick();
        cyc("reset_out", 1'b0, 1'b0, 2'd0, 32'h0);
        chk("reset_vld", vld, 4'b0000);
        RSTn = 1'b1;

        // single page load and entry latency
        wr_en = 4'b0100;
        wr_data[95:64] = 32'h1234_5678;
        tick();
        wr_en = '0;
        chk("load_vld", vld, 4'b0100);
        chk("load_e", e, 1'b0);
        tick();
        cyc("entry", 1'b1, 1'b1, 2'd2, 32'h1234_5678);
        tick();
        cyc("entry_swap_once", 1'b1, 1'b0, 2'd2, 32'h1234_5678);

        // lone page never blanks or swaps
        for (int i = 0; i < 100; i++) begin
            tick();
            cyc("lone_page", 1'b1, 1'b0, 2'd2, 32'h1234_5678);
        end
        wr_en = 4'b0100;
        wr_data[95:64] = 32'hDEAD_BEEF;
        tick();
        wr_en = '0;
        tick();
        cyc("reload", 1'b1, 1'b0, 2'd2, 32'hDEAD_BEEF);

        // clear during show
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_vld", vld, 4'b0000);
        tick();
        cyc("clr_idle", 1'b0, 1'b0, 2'd2, 32'h0);
        tick();
        cyc("clr_stay_idle", 1'b0, 1'b0, 2'd2, 32'h0);

        // clear and load in the same cycle
        clr = 1'b1;
        wr_en = 4'b0010;
        wr_data[63:32] = 32'hAAAA_5555;
        tick();
        clr = 1'b0;
        wr_en = '0;
        chk("clr_wr_vld", vld, 4'b0010);
        tick();
        cyc("clr_wr_entry", 1'b1, 1'b1, 2'd1, 32'hAAAA_5555);

        // fresh start for rotation
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        wr_en = 4'b1011;
        wr_data = {D3, 32'h0, D1, D0};
        tick();
        wr_en = '0;
        chk("rot_vld", vld, 4'b1011);
        chk("rot_e", e, 1'b0);
        tick();
        run_page(2'd0, D0);
        run_page(2'd1, D1);
        run_page(2'd3, D3);
        run_page(2'd0, D0);

        // hold on page 1, then manual step
        cyc("hold_entry", 1'b1, 1'b1, 2'd1, D1);
        hold = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            cyc("hold", 1'b1, 1'b0, 2'd1, D1);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("step_blank", 1'b0, 1'b0, 2'd1, D1);
            tick();
        end
        cyc("step_entry", 1'b1, 1'b1, 2'd3, D3);

        // async reset in the middle of a blank gap
        step = 1'b1;
        tick();
        step = 1'b0;
        cyc("pre_rst_blank", 1'b0, 1'b0, 2'd3, D3);
        #2;
        RSTn = 1'b0;
        #1;
        cyc("async_rst", 1'b0, 1'b0, 2'd0, 32'h0);
        chk("async_rst_vld", vld, 4'b0000);
        #3;
        RSTn = 1'b1;
        hold = 1'b0;
        tick();
        tick();
        tick();
        cyc("post_rst_idle", 1'b0, 1'b0, 2'd0, 32'h0);
        chk("post_rst_vld", vld, 4'b0000);
        wr_en = 4'b0001;
        wr_data = '0;
        wr_data[31:0] = 32'hCAFE_0001;
        tick();
        wr_en = '0;
        tick();
        cyc("post_rst_entry", 1'b1, 1'b1, 2'd0, 32'hCAFE_0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
